sbox_ti_layer: RTL and testbench
================================

# sbox_ti_layer

Serialised, parametrised 3-share threshold-implementation (TI) layer for the 5-bit quadratic Fides S-box. It applies the S-box to all NUM_SBOX nibbles of a shared state, LANES S-boxes per clock. Each lane applies the non-complete component functions, with optional fresh-mask refresh. The state register is the mandatory TI register between nonlinear layers. The block sits in the round datapath of the masked Fides-160 core between the key-addition and linear-mix stages.

## Interface
- NUM_SBOX, 32, number of 5-bit S-boxes in the state (160/5).
- LANES, 4, S-box instances evaluated per cycle; must divide NUM_SBOX.
- REMASK, 0, 1 = refresh output shares with rnd each RUN cycle.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input shares valid.
- in_ready  out  1  block can accept a state.
- in_a1, in_a2, in_a3  in  5*NUM_SBOX each  input shares; S-box k occupies bits [5k+4:5k], bit 5k+4 = x0 (MSB).
- rnd  in  10*LANES  fresh randomness. Lane j uses r0 = rnd[10j+4:10j] and r1 = rnd[10j+9:10j+5]. Ignored when REMASK=0.
- out_valid  out  1  output shares valid.
- out_ready  in  1  consumer accepts output.
- out_y1, out_y2, out_y3  out  5*NUM_SBOX each  output shares, same bit mapping as inputs.

## Operation
- S-box, unshared, x0 = MSB, y0 = MSB:
  - y0 = x3^x2^x1^x2x3^x1x4^x0x3^x0x2
  - y1 = x3^x0^x2x4^x2x3^x1x3^x1x2
  - y2 = x1^x0^x2x4^x2x3^x0x4^x0x1
  - y3 = x0^x3x4^x1x2^x0x4^x0x2
  - y4 = 1^x4^x1^x2x4^x0x3
  - Resulting table, x = 0..31: 1 0 25 26 17 29 21 27 20 5 4 23 14 18 2 28 15 8 6 3 13 7 24 16 30 9 31 10 22 12 11 19.
- Direct sharing, non-complete. Share i is computed only from shares i+1 and i+2 (indices mod 3):
  - Linear term x contributes x^(2) to f1, x^(3) to f2 and x^(1) to f3.
  - Quadratic term ab contributes a2b2^a2b3^a3b2 to f1, a3b3^a3b1^a1b3 to f2 and a1b1^a1b2^a2b1 to f3.
  - Constant 1 goes to f1 only.
- REMASK=1: per lane, f1^=r0, f2^=r1, f3^=r0^r1. REMASK=0: no refresh.
- FSM states: IDLE, RUN, DONE. Counter cnt is ceil(log2(NUM_SBOX/LANES)) bits wide.
  - IDLE: in_ready=1. When in_valid=1, load in_a* into share registers s1..s3, set cnt=0 and move to RUN.
  - RUN: lanes take S-boxes 0..LANES-1 (lowest bits) of s1..s3. Each share register shifts right by 5*LANES, and the f outputs are written into the top 5*LANES bits. cnt increments. After the cycle with cnt = NUM_SBOX/LANES-1, move to DONE. After NUM_SBOX/LANES rotations every S-box is back at its original position.
  - DONE: out_valid=1 and out_y* = s1..s3. When out_ready=1, move to IDLE. No same-cycle reload: in_ready=0 in DONE.
- out_y* are forced to 0 whenever out_valid=0, so no partial state is visible.
- Shares are never recombined inside the block. No signal combines all three shares of any variable.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, cnt=0, s1..s3=0. Resulting outputs: in_ready=1, out_valid=0, out_y*=0.
- Reset has priority over every transition. Asserting it during RUN or DONE aborts the operation, and the partial state is discarded (zeroed).
- Latency:
  - Input handshake at edge E0.
  - RUN occupies edges E1..EC, C = NUM_SBOX/LANES.
  - out_valid=1 from just after EC.
- Default parameters: C=8, and out_valid rises 9 edges after acceptance.
- Minimum period between accepted states is C+2 cycles.
- DONE holds outputs stable indefinitely while out_ready=0.
- rnd is sampled at each RUN edge and must be fresh every cycle.
- in_a* are sampled only at the accepting edge.

## Test plan
- Each single S-box with in_a1=x, in_a2=in_a3=0, over all 32 x (REMASK=0) -> XOR of out_y shares equals the table; spot checks: x=0 gives 1, x=1 gives 0, x=2 gives 25, x=31 gives 19.
- Full state (NUM_SBOX=32, LANES=4) with random shares, 1000 vectors -> recombined output equals the S-box applied per nibble in the original positions; out_valid rises exactly 9 edges after acceptance.
- Non-completeness: fix in_a2 and in_a3, vary in_a1 (REMASK=0) -> out_y1 is bit-identical across runs, while out_y2 and out_y3 change.
- REMASK=1 with rnd all-ones -> recombined output is unchanged; out_y1 differs from the REMASK=0 result by 5'h1F in every nibble, out_y3 by 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_y* and in_ready=0 are stable; an in_valid pulse during this window is ignored.
- Reset mid-RUN at cnt=3, then a new state applied -> immediately after reset: IDLE, in_ready=1, outputs 0; the new state produces correct results with no trace of the aborted one.

Source files
------------

// File: rtl/sbox_ti_layer.sv
// sbox_ti_layer: serialised 3-share threshold implementation of the 5-bit
// quadratic Fides S-box. A shared state of NUM_SBOX S-boxes is rotated
// through LANES S-box instances per cycle; the share registers are the TI
// register stage between nonlinear layers.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         input handshake (in_ready high only in IDLE)
//   in_a1, in_a2, in_a3         input shares, S-box k at bits [5k+4:5k]
//   rnd                         10 bits per lane: r0 = [10j+4:10j], r1 = [10j+9:10j+5]
//   out_valid / out_ready       output handshake (out_valid high only in DONE)
//   out_y1, out_y2, out_y3      output shares, zero whenever out_valid is low
module sbox_ti_layer #(
  parameter int unsigned NUM_SBOX = 32,
  parameter int unsigned LANES    = 4,
  parameter int unsigned REMASK   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [5*NUM_SBOX-1:0]   in_a1,
  input  logic [5*NUM_SBOX-1:0]   in_a2,
  input  logic [5*NUM_SBOX-1:0]   in_a3,
  input  logic [10*LANES-1:0]     rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [5*NUM_SBOX-1:0]   out_y1,
  output logic [5*NUM_SBOX-1:0]   out_y2,
  output logic [5*NUM_SBOX-1:0]   out_y3
);

  localparam int unsigned W  = 5 * NUM_SBOX;
  localparam int unsigned LW = 5 * LANES;
  localparam int unsigned C  = NUM_SBOX / LANES;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Shared AND term: a*b split over the two shares handed to one component.
  function automatic logic qd(input logic pa, input logic pb,
                              input logic qa, input logic qb);
    return (pa & pb) ^ (pa & qb) ^ (qa & pb);
  endfunction

  // One non-complete component function. p supplies the linear terms and the
  // square products, q the cross products; bit 4 = x0/y0, bit 0 = x4/y4.
  function automatic logic [4:0] f_share(input logic [4:0] p, input logic [4:0] q,
                                         input logic one);
    logic [4:0] y;
    y[4] = p[3] ^ p[2] ^ p[1]
         ^ qd(p[2], p[1], q[2], q[1]) ^ qd(p[3], p[0], q[3], q[0])
         ^ qd(p[4], p[1], q[4], q[1]) ^ qd(p[4], p[2], q[4], q[2]);
    y[3] = p[1] ^ p[4]
         ^ qd(p[2], p[0], q[2], q[0]) ^ qd(p[2], p[1], q[2], q[1])
         ^ qd(p[3], p[1], q[3], q[1]) ^ qd(p[3], p[2], q[3], q[2]);
    y[2] = p[3] ^ p[4]
         ^ qd(p[2], p[0], q[2], q[0]) ^ qd(p[2], p[1], q[2], q[1])
         ^ qd(p[4], p[0], q[4], q[0]) ^ qd(p[4], p[3], q[4], q[3]);
    y[1] = p[4]
         ^ qd(p[1], p[0], q[1], q[0]) ^ qd(p[3], p[2], q[3], q[2])
         ^ qd(p[4], p[0], q[4], q[0]) ^ qd(p[4], p[2], q[4], q[2]);
    y[0] = one ^ p[0] ^ p[3]
         ^ qd(p[2], p[0], q[2], q[0]) ^ qd(p[4], p[1], q[4], q[1]);
    return y;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [LW-1:0] f1, f2, f3;

  // Lane datapath: share i is built only from shares i+1 and i+2.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [4:0] r0, r1;
    assign r0 = (REMASK != 0) ? rnd[10*j +: 5]     : 5'd0;
    assign r1 = (REMASK != 0) ? rnd[10*j + 5 +: 5] : 5'd0;
    assign f1[5*j +: 5] = f_share(s2_q[5*j +: 5], s3_q[5*j +: 5], 1'b1) ^ r0;
    assign f2[5*j +: 5] = f_share(s3_q[5*j +: 5], s1_q[5*j +: 5], 1'b0) ^ r1;
    assign f3[5*j +: 5] = f_share(s1_q[5*j +: 5], s2_q[5*j +: 5], 1'b0) ^ r0 ^ r1;
  end

  // Next-state, counter and share-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s1_d    = in_a1;
          s2_d    = in_a2;
          s3_d    = in_a3;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Rotate right by one lane group; results re-enter at the top so the
        // state returns to its original alignment after C cycles.
        s1_d = (W'(f1) << (W - LW)) | (s1_q >> LW);
        s2_d = (W'(f2) << (W - LW)) | (s2_q >> LW);
        s3_d = (W'(f3) << (W - LW)) | (s3_q >> LW);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(C - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          // Do not retain consumed shares.
          s1_d    = '0;
          s2_d    = '0;
          s3_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // Gate each share separately so partial RUN state never reaches the port.
  assign out_y1 = s1_q & {W{out_valid_q}};
  assign out_y2 = s2_q & {W{out_valid_q}};
  assign out_y3 = s3_q & {W{out_valid_q}};

endmodule

// File: tb/tb_sbox_ti_layer.sv
// tb_sbox_ti_layer: directed bench for sbox_ti_layer. Two instances share all
// inputs: dut (REMASK=0) and dut_rm (REMASK=1).
module tb_sbox_ti_layer;

  localparam int unsigned NS = 32;
  localparam int unsigned LN = 4;
  localparam int unsigned W  = 5 * NS;
  localparam int unsigned C  = NS / LN;

  localparam logic [4:0] SBOX [32] = '{
    5'd1,  5'd0,  5'd25, 5'd26, 5'd17, 5'd29, 5'd21, 5'd27,
    5'd20, 5'd5,  5'd4,  5'd23, 5'd14, 5'd18, 5'd2,  5'd28,
    5'd15, 5'd8,  5'd6,  5'd3,  5'd13, 5'd7,  5'd24, 5'd16,
    5'd30, 5'd9,  5'd31, 5'd10, 5'd22, 5'd12, 5'd11, 5'd19};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  a1, a2, a3;
  logic [10*LN-1:0] rnd;
  logic          rnd_ones;
  logic          in_ready, out_valid, in_ready_rm, out_valid_rm;
  logic [W-1:0]  y1, y2, y3, z1, z2, z3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sbox_ti_layer #(.NUM_SBOX(NS), .LANES(LN), .REMASK(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a1(a1), .in_a2(a2), .in_a3(a3), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y1(y1), .out_y2(y2), .out_y3(y3));

  sbox_ti_layer #(.NUM_SBOX(NS), .LANES(LN), .REMASK(1)) dut_rm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_rm),
    .in_a1(a1), .in_a2(a2), .in_a3(a3), .rnd(rnd),
    .out_valid(out_valid_rm), .out_ready(out_ready),
    .out_y1(z1), .out_y2(z2), .out_y3(z3));

  // Fresh randomness every cycle, or all-ones for the refresh comparison.
  always @(negedge clk) begin
    if (rnd_ones) rnd = '1;
    else          rnd = 40'({$urandom(), $urandom()});
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    return W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [W-1:0] sbox_state(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NS; k++) r[5*k +: 5] = SBOX[x[5*k +: 5]];
    return r;
  endfunction

  // Present one state and complete the accepting edge; inputs then get junk.
  task automatic accept(input logic [W-1:0] b1, input logic [W-1:0] b2, input logic [W-1:0] b3);
    check("ready_before_accept", W'(in_ready), W'(1));
    a1 = b1; a2 = b2; a3 = b3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a1 = rand_w(); a2 = rand_w(); a3 = rand_w();
  endtask

  // Edges after the accepting edge until out_valid: C, i.e. 9 counting acceptance.
  task automatic wait_done();
    int edges;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency_edges", W'(edges), W'(C));
    check("rm_valid_align", W'(out_valid_rm), W'(1));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_done", W'({out_valid, in_ready}), W'(2'b01));
    check("y_zero_after_done", y1 | y2 | y3, '0);
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] b1,
                           input logic [W-1:0] b2, input logic [W-1:0] b3);
    accept(b1, b2, b3);
    wait_done();
    check(tag, y1 ^ y2 ^ y3, sbox_state(b1 ^ b2 ^ b3));
    check({tag, "_rm"}, z1 ^ z2 ^ z3, sbox_state(b1 ^ b2 ^ b3));
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v1, v2, v3, c1, c2, c3, ones;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_ones = 1'b0;
    a1 = '0; a2 = '0; a3 = '0;
    ones = {NS{5'h1F}};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_y", y1 | y2 | y3, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Every S-box input value once: nibble k holds x = k in share 1 only.
    v1 = '0;
    for (int k = 0; k < NS; k++) v1[5*k +: 5] = 5'(k);
    accept(v1, '0, '0);
    wait_done();
    c1 = y1 ^ y2 ^ y3;
    for (int k = 0; k < NS; k++)
      check($sformatf("sbox_x%0d", k), W'(c1[5*k +: 5]), W'(SBOX[k]));
    release_out();

    // Non-completeness: share 1 output depends only on shares 2 and 3.
    v2 = rand_w();
    v3 = {NS{5'h01}};
    run_check("nc_a", '0, v2, v3);
    c1 = y1; c2 = y2; c3 = y3;
    release_out();
    run_check("nc_b", ones, v2, v3);
    check("nc_y1_same", y1, c1);
    check("nc_y2_changes", W'(y2 != c2), W'(1));
    check("nc_y3_changes", W'(y3 != c3), W'(1));
    release_out();

    // Refresh with all-ones randomness.
    rnd_ones = 1'b1;
    @(posedge clk); #1;
    run_check("remask", rand_w(), rand_w(), rand_w());
    check("remask_y1", z1, y1 ^ ones);
    check("remask_y2", z2, y2 ^ ones);
    check("remask_y3", z3, y3);
    release_out();
    rnd_ones = 1'b0;

    // Backpressure: DONE holds, in_valid pulse ignored.
    v1 = rand_w(); v2 = rand_w(); v3 = rand_w();
    run_check("bp", v1, v2, v3);
    c1 = y1; c2 = y2; c3 = y3;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      @(posedge clk); #1;
      check("bp_hold_flags", W'({out_valid, in_ready}), W'(2'b10));
      check("bp_hold_y1", y1, c1);
      check("bp_hold_y2", y2, c2);
      check("bp_hold_y3", y3, c3);
    end
    in_valid = 1'b0;
    release_out();
    @(posedge clk); #1;
    check("bp_still_idle", W'({out_valid, in_ready}), W'(2'b01));

    // Reset mid-RUN at cnt=3, then a clean new state.
    accept(rand_w(), rand_w(), rand_w());
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_flags", W'({out_valid, in_ready}), W'(2'b01));
    check("mid_rst_y", y1 | y2 | y3, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_check("after_abort", rand_w(), rand_w(), rand_w());
    release_out();

    // Random shares with fresh randomness.
    for (int n = 0; n < 1000; n++) begin
      run_check("rand_vec", rand_w(), rand_w(), rand_w());
      release_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
